mult_share_arb: RTL and testbench
=================================

# mult_share_arb

Two-port arbiter and sequencer that time-shares one combinational 4x4 array multiplier core between two independent requesters. It accepts operand pairs over valid/ready handshakes and grants the core round-robin. It registers operands into the core and returns each registered product on the winning requester's response channel. It sits between the top-level pin mux and the multiplier core, and owns all sequencing around the otherwise stateless datapath.

## Interface
- WIDTH, 4, operand width in bits; product width is 2*WIDTH.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  requester k presents an operand pair.
- req0_ready / req1_ready  out  1  block accepts from requester k this cycle.
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands of requester k.
- rsp0_valid / rsp1_valid  out  1  product available for requester k.
- rsp0_ready / rsp1_ready  in  1  requester k consumes the product.
- rsp_p  out  2*WIDTH  product; shared by both ports and qualified by rspk_valid.
- mul_a, mul_b  out  WIDTH  operands driven to the multiplier core.
- mul_p  in  2*WIDTH  product returned from the core (combinational).
- op_count  out  8  number of completed responses, wraps 0xFF->0x00.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant is combinational. With one valid requester, that requester wins. With both valid, the winner is set by the prio bit (prio=0 → port 0 wins, prio=1 → port 1 wins).
  - Only the winner sees reqk_ready=1. The loser sees reqk_ready=0.
  - On valid&ready: latch a/b into the operand registers, record owner=k, go to CALC.
  - With no requester valid, stay in IDLE.
- CALC:
  - mul_a/mul_b are driven from the operand registers. Both are held at 0 in every other state.
  - At the clock edge, capture mul_p into the result register and go to RESP.
- RESP:
  - rsp_p holds the result and rsp<owner>_valid=1. The other port's valid stays 0.
  - When rsp<owner>_ready=1: op_count increments, prio becomes ~owner, and the FSM returns to IDLE.
  - With rsp<owner>_ready low, hold indefinitely with no timeout. Both req ready outputs stay 0.
- Arithmetic: unsigned, rsp_p = a*b exactly, no truncation (0xF*0xF=0xE1).
- Deassertion of reqk_valid before acceptance carries no obligation. A requester may change operands freely until it is accepted.
- Reset, including reset mid-operation, abandons the transaction. No response is produced afterwards.
- Reset values: state=IDLE, prio=0, op_count=0, rsp_p=0, mul_a=mul_b=0, all ready/valid outputs 0 (req ready in IDLE is purely combinational from valid), busy=0.

## Timing
- Accept edge at cycle N (IDLE, valid&ready).
- Cycle N+1: CALC, operands on the core.
- Cycle N+2: RESP, rspk_valid=1 and rsp_p valid.
- If rspk_ready is high in cycle N+2, the response completes at that edge and the FSM is back in IDLE at N+3. The next accept can happen in N+3.
- Minimum spacing is 3 cycles per operation.
- Both reqk_valid asserted in IDLE: exactly one port is accepted. The other is accepted at the next IDLE if it is still valid. This gives strict alternation under constant contention.
- op_count and prio update on the same edge as the response handshake.
- All outputs except reqk_ready are registered or decoded from registered state only.
- Asynchronous reset forces reset values immediately. Release is synchronized by the top level.

## Structure
- Shared package mult_pkg:
  - WIDTH constant.
  - State enum {IDLE, CALC, RESP}.
  - Owner/prio type (1-bit port index).
- Sub-module mult_core: the combinational 4x4 array multiplier built from full-adder cells.
  - Instantiated by the top level and wired to mul_a/mul_b/mul_p.
  - Not instantiated inside the arbiter.
- The bench binds a golden a*b model onto mul_p in place of the core.

## Test plan
- Single request: port 0, a=0x3, b=0x5, rsp0_ready=1 → rsp0_valid at N+2 with rsp_p=0x0F; op_count=1; rsp1_valid never asserts.
- Extremes: port 1 sends 0xF*0xF, then 0x0*0xA → rsp_p=0xE1, then 0x00.
- Contention: both valid continuously with distinct operands → accepts alternate 0,1,0,1 starting with port 0 after reset; each product matches its owner.
- Backpressure: rsp0_ready low for 10 cycles → rsp0_valid and rsp_p stable; req0_ready and req1_ready stay 0; completion one edge after ready rises.
- Reset mid-operation: assert rst_n=0 in CALC → all outputs at reset values immediately; no rsp_valid after release; prio=0, op_count=0.
- Wrap: 256 completed operations → op_count returns to 0x00.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Shared types and constants for the shared-multiplier arbiter and its core.
package mult_pkg;

    // Operand width; products are twice as wide.
    localparam int WIDTH  = 4;
    localparam int PWIDTH = 2 * WIDTH;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Requester index, used both for the transaction owner and for priority.
    typedef logic port_t;
    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
        full_add = {(x & y) | (c & (x ^ y)), x ^ y ^ c};
    endfunction

endpackage

// File: rtl/mult_share_arb_core.sv
// Combinational unsigned array multiplier. Each row adds one shifted partial
// product into the running sum through a ripple of full-adder cells.
module mult_core
    import mult_pkg::*;
(
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic [PWIDTH-1:0] p_o
);

    logic [PWIDTH-1:0] acc_s;
    logic              carry_s;
    logic [1:0]        fa_s;

    // Accumulate the partial-product rows; bit i+WIDTH of the sum is still
    // zero when row i is added, so the row's final carry lands there.
    always_comb begin
        acc_s   = {{WIDTH{1'b0}}, a_i & {WIDTH{b_i[0]}}};
        carry_s = 1'b0;
        fa_s    = 2'b00;
        for (int i = 1; i < WIDTH; i++) begin
            carry_s = 1'b0;
            for (int j = 0; j < WIDTH; j++) begin
                fa_s          = full_add(acc_s[i+j], a_i[j] & b_i[i], carry_s);
                acc_s[i+j]    = fa_s[0];
                carry_s       = fa_s[1];
            end
            acc_s[i+WIDTH] = carry_s;
        end
        p_o = acc_s;
    end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin arbiter and sequencer that time-shares one external
// combinational multiplier between two valid/ready requesters.
module mult_share_arb
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_a,
    input  logic [WIDTH-1:0]  req0_b,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_a,
    input  logic [WIDTH-1:0]  req1_b,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [PWIDTH-1:0] rsp_p,
    output logic [WIDTH-1:0]  mul_a,
    output logic [WIDTH-1:0]  mul_b,
    input  logic [PWIDTH-1:0] mul_p,
    output logic [7:0]        op_count,
    output logic              busy
);

    state_e             state_q,  state_d;
    port_t              owner_q,  owner_d;
    port_t              prio_q,   prio_d;
    logic [WIDTH-1:0]   a_q,      a_d;
    logic [WIDTH-1:0]   b_q,      b_d;
    logic [PWIDTH-1:0]  result_q, result_d;
    logic [7:0]         count_q,  count_d;

    logic   idle_s;
    logic   calc_s;
    logic   resp_s;
    logic   any_req_s;
    port_t  grant_s;
    logic   owner_ready_s;

    assign idle_s    = (state_q == IDLE);
    assign calc_s    = (state_q == CALC);
    assign resp_s    = (state_q == RESP);
    assign any_req_s = req0_valid | req1_valid;

    // Port 1 wins when it is the only requester or when it holds priority.
    assign grant_s = (req1_valid & (prio_q | ~req0_valid)) ? PORT1 : PORT0;

    // Acceptance is the only combinational path to an output.
    assign req0_ready = idle_s & req0_valid & (grant_s == PORT0);
    assign req1_ready = idle_s & req1_valid & (grant_s == PORT1);

    assign owner_ready_s = (owner_q == PORT1) ? rsp1_ready : rsp0_ready;

    assign rsp0_valid = resp_s & (owner_q == PORT0);
    assign rsp1_valid = resp_s & (owner_q == PORT1);
    assign rsp_p      = result_q;
    assign mul_a      = calc_s ? a_q : {WIDTH{1'b0}};
    assign mul_b      = calc_s ? b_q : {WIDTH{1'b0}};
    assign op_count   = count_q;
    assign busy       = ~idle_s;

    // Next-state logic: accept in IDLE, sample the core in CALC, hand off in RESP.
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (any_req_s) begin
                    owner_d = grant_s;
                    a_d     = (grant_s == PORT1) ? req1_a : req0_a;
                    b_d     = (grant_s == PORT1) ? req1_b : req0_b;
                    state_d = CALC;
                end else begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                result_d = mul_p;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_ready_s) begin
                    count_d = count_q + 8'd1;
                    prio_d  = ~owner_q;
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= PORT0;
            prio_q   <= PORT0;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            result_q <= {PWIDTH{1'b0}};
            count_q  <= 8'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: tb/tb_mult_share_arb.sv
// Scoreboard bench for mult_share_arb with a golden multiplier on mul_p.
module tb_mult_share_arb;
    import mult_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0] req0_a, req0_b, req1_a, req1_b;
    logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
    logic [7:0] rsp_p, mul_p, op_count;
    logic [3:0] mul_a, mul_b;
    logic       busy;

    logic [3:0] core_a, core_b;
    logic [7:0] core_p;

    typedef struct packed {
        logic       port;
        logic [7:0] p;
    } exp_t;
    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // Golden model stands in for the multiplier core.
    assign mul_p = {4'd0, mul_a} * {4'd0, mul_b};

    mult_share_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_p(rsp_p), .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .op_count(op_count), .busy(busy)
    );

    mult_core u_core (.a_i(core_a), .b_i(core_b), .p_o(core_p));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented response must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp0_valid && rsp1_valid) begin
                checks++;
                errors++;
                $display("FAIL both_rsp_valid: got 1/1, expected at most one at %0t", $time);
            end else if (rsp0_valid || rsp1_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rsp: port %0d p=0x%0h with no expectation at %0t",
                             rsp1_valid, rsp_p, $time);
                end else begin
                    if (exp_q[0].port !== rsp1_valid || exp_q[0].p !== rsp_p) begin
                        errors++;
                        $display("FAIL rsp_match: got port %0d p=0x%0h, expected port %0d p=0x%0h at %0t",
                                 rsp1_valid, rsp_p, exp_q[0].port, exp_q[0].p, $time);
                    end
                    if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 4'd0; req0_b = 4'd0; req1_a = 4'd0; req1_b = 4'd0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b0;
        #1;
        chk("rst_busy",     32'(busy),       32'd0);
        chk("rst_op_count", 32'(op_count),   32'd0);
        chk("rst_rsp_p",    32'(rsp_p),      32'd0);
        chk("rst_mul_ab",   32'({mul_a, mul_b}), 32'd0);
        chk("rst_rsp_vld",  32'({rsp0_valid, rsp1_valid}), 32'd0);
        chk("rst_req_rdy",  32'({req0_ready, req1_ready}), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        logic got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = !busy;
        end
        chk("idle_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    // Issue one request on a port, wait for acceptance and completion.
    task automatic do_op(input logic port, input logic [3:0] a, input logic [3:0] b,
                         input logic [7:0] exp_p);
        logic got;
        exp_q.push_back('{port, exp_p});
        if (port) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = port ? req1_ready : req0_ready;
        end
        chk("accept_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       got;
        int         acc;
        logic [3:0] wa, wb;
        logic [7:0] we;

        // Standalone check of the array multiplier over all operand pairs.
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 0; bi < 16; bi++) begin
                core_a = 4'(ai);
                core_b = 4'(bi);
                #1;
                chk("core_product", 32'(core_p), 32'(ai * bi));
            end
        end

        do_reset();

        // Single request on port 0 with cycle-accurate latency checks.
        rsp0_ready = 1'b1;
        exp_q.push_back('{1'b0, 8'h0F});
        req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h5;
        @(negedge clk);
        chk("t1_req_rdy", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_calc_busy", 32'(busy), 32'd1);
        chk("t1_calc_mul",  32'({mul_a, mul_b}), 32'h35);
        chk("t1_calc_vld",  32'(rsp0_valid), 32'd0);
        @(negedge clk);
        chk("t1_resp_vld",  32'(rsp0_valid), 32'd1);
        chk("t1_resp_p",    32'(rsp_p), 32'h0F);
        chk("t1_resp_mul",  32'({mul_a, mul_b}), 32'h00);
        @(negedge clk);
        chk("t1_done_busy", 32'(busy), 32'd0);
        chk("t1_op_count",  32'(op_count), 32'd1);
        @(posedge clk);
        #1;

        // Extremes on port 1.
        rsp1_ready = 1'b1;
        do_op(1'b1, 4'hF, 4'hF, 8'hE1);
        do_op(1'b1, 4'h0, 4'hA, 8'h00);
        chk("t2_op_count", 32'(op_count), 32'd3);

        // Contention after reset: strict alternation starting with port 0.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_q.push_back('{1'b0, 8'h06});
        exp_q.push_back('{1'b1, 8'h3F});
        exp_q.push_back('{1'b0, 8'h06});
        exp_q.push_back('{1'b1, 8'h3F});
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3;
        req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h9;
        acc = 0;
        for (int i = 0; i < 60 && acc < 4; i++) begin
            @(negedge clk);
            if (req0_ready && req1_ready) begin
                chk("t3_both_ready", 32'd1, 32'd0);
            end
            if (req0_ready || req1_ready) acc++;
        end
        chk("t3_accepts", 32'(acc), 32'd4);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("t3_op_count", 32'(op_count), 32'd4);

        // Backpressure: hold the response for ten cycles.
        rsp0_ready = 1'b0;
        exp_q.push_back('{1'b0, 8'h9C});
        req0_valid = 1'b1; req0_a = 4'hC; req0_b = 4'hD;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = req0_ready;
        end
        chk("t4_accept", 32'(got), 32'd1);
        @(posedge clk);
        #1 req0_a = 4'h1; req1_valid = 1'b1; req1_a = 4'h4; req1_b = 4'h4;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = rsp0_valid;
        end
        chk("t4_rsp_seen", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) begin
            chk("t4_hold_vld", 32'(rsp0_valid), 32'd1);
            chk("t4_hold_p",   32'(rsp_p), 32'h9C);
            chk("t4_hold_rdy", 32'({req0_ready, req1_ready}), 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1;
        @(negedge clk);
        chk("t4_still_vld", 32'(rsp0_valid), 32'd1);
        @(negedge clk);
        chk("t4_done_vld",  32'(rsp0_valid), 32'd0);
        chk("t4_done_busy", 32'(busy), 32'd0);
        chk("t4_op_count",  32'(op_count), 32'd5);
        @(posedge clk);
        #1;

        // Reset in CALC abandons the transaction.
        req0_valid = 1'b1; req0_a = 4'h5; req0_b = 4'h5;
        @(posedge clk);
        #1 req0_valid = 1'b0;
        chk("t5_in_calc", 32'({busy, mul_a, mul_b}), 32'h155);
        do_reset();
        repeat (6) @(posedge clk);
        #1;
        // Priority is back at port 0 after reset.
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        exp_q.push_back('{1'b0, 8'h06});
        req0_valid = 1'b1; req0_a = 4'h2; req0_b = 4'h3;
        req1_valid = 1'b1; req1_a = 4'h7; req1_b = 4'h9;
        @(negedge clk);
        chk("t5_prio_rdy", 32'({req0_ready, req1_ready}), 32'b10);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_idle();
        chk("t5_op_count", 32'(op_count), 32'd1);

        // Counter wrap after 256 completions.
        do_reset();
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            wa = 4'(i);
            wb = 4'(i >> 4);
            we = {4'd0, wa} * {4'd0, wb};
            do_op(1'(i), wa, wb, we);
            if (i == 254) chk("t6_count_ff", 32'(op_count), 32'hFF);
        end
        chk("t6_count_wrap", 32'(op_count), 32'h00);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
